// File: rtl/btn_seq_pkg.sv
// Shared types and helpers for the button-sequence detector.
// Holds the FSM state encoding and the timer-width helper.
package btn_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2,
        COOL  = 2'd3
    } state_e;

    // Bits needed to hold max(arm, cool) - 1, never less than one.
    function automatic int timer_w(input int arm, input int cool);
        int m;
        m = (arm > cool) ? arm : cool;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_seq_timer.sv
// Loadable down-counter shared by the ARM and COOL phases.
// Ports: clk, rst_n, load_i, load_val_i -> zero_o (count == 0).
module btn_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Free-running decrement, parked at zero until the next load.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/btn_seq_detector.sv
// Button-sequence detector: trigger -> ARM -> CHECK -> COOL pulse shaper.
// Ports: clk, rst_n, b, trig_mask, conf_mask, hit_clr -> outp, busy,
// state_o, hit_cnt. Macro BTN_SYNC_EN adds a 2-flop input synchroniser.
module btn_seq_detector
    import btn_seq_pkg::*;
#(
    parameter int NUM_BTN     = 3,
    parameter int ARM_CYCLES  = 2,
    parameter int COOL_CYCLES = 4,
    parameter int MOD_IDX     = NUM_BTN - 1,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] b,
    input  logic [NUM_BTN-1:0] trig_mask,
    input  logic [NUM_BTN-1:0] conf_mask,
    input  logic               hit_clr,
    output logic               outp,
    output logic               busy,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   hit_cnt
);

    localparam int TW = timer_w(ARM_CYCLES, COOL_CYCLES);
    localparam logic [TW-1:0] ARM_LD  = TW'(ARM_CYCLES - 1);
    localparam logic [TW-1:0] COOL_LD = TW'(COOL_CYCLES - 1);
    localparam logic [NUM_BTN-1:0] MOD_BIT = NUM_BTN'(1) << MOD_IDX;

    logic [NUM_BTN-1:0] b_s;

`ifdef BTN_SYNC_EN
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= b;
            sync2_q <= sync1_q;
        end
    end

    assign b_s = sync2_q;
`else
    assign b_s = b;
`endif

    state_e             state_q, state_d;
    logic [NUM_BTN-1:0] t_q, t_d;
    logic [NUM_BTN-1:0] c_q, c_d;
    logic [CNT_W-1:0]   hit_q, hit_d;
    logic [NUM_BTN-1:0] bm;
    logic               tmr_ld;
    logic [TW-1:0]      tmr_val;
    logic               tmr_zero;
    logic               inc;

    // The modifier never counts as a trigger or confirm button.
    assign bm = b_s & ~MOD_BIT;

    btn_seq_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_ld),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        c_d     = c_q;
        tmr_ld  = 1'b0;
        tmr_val = '0;
        inc     = 1'b0;
        outp    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|(bm & trig_mask)) begin
                    state_d = ARM;
                    t_d     = trig_mask;
                    c_d     = conf_mask;
                    tmr_ld  = 1'b1;
                    tmr_val = ARM_LD;
                end
            end
            ARM: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                    // Modifier held with a live trigger fires one cycle early.
                    outp    = b_s[MOD_IDX] & |(bm & t_q);
                end
            end
            CHECK: begin
                outp = 1'b1;
                if (|(bm & c_q)) begin
                    state_d = COOL;
                    tmr_ld  = 1'b1;
                    tmr_val = COOL_LD;
                    inc     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            COOL: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over a same-cycle increment; count saturates.
    always_comb begin
        hit_d = hit_q;
        if (hit_clr) begin
            hit_d = '0;
        end else if (inc && !(&hit_q)) begin
            hit_d = hit_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            c_q     <= '0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            c_q     <= c_d;
            hit_q   <= hit_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign state_o = state_q;
    assign hit_cnt = hit_q;

endmodule

// File: tb/tb_btn_seq_detector.sv
// Directed self-checking bench for btn_seq_detector.
// A second instance with a 2-bit counter checks saturation.
module tb_btn_seq_detector;

`ifdef BTN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] b;
    logic [2:0] tm;
    logic [2:0] cm;
    logic       clr;
    logic       outp, busy, outp2, busy2;
    logic [1:0] st, st2;
    logic [7:0] hit;
    logic [1:0] hit2;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;

    typedef struct packed {
        logic [2:0] b;
        logic [2:0] cm;
        logic       clr;
        logic [1:0] st;
        logic       o;
    } vec_t;

    vec_t q[$];

    always #5 clk = ~clk;

    btn_seq_detector u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .b         (b),
        .trig_mask (tm),
        .conf_mask (cm),
        .hit_clr   (clr),
        .outp      (outp),
        .busy      (busy),
        .state_o   (st),
        .hit_cnt   (hit)
    );

    btn_seq_detector #(
        .CNT_W (2)
    ) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .b         (b),
        .trig_mask (tm),
        .conf_mask (cm),
        .hit_clr   (clr),
        .outp      (outp2),
        .busy      (busy2),
        .state_o   (st2),
        .hit_cnt   (hit2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [2:0] bv, input logic [2:0] cv,
                       input logic cl, input logic [1:0] s, input logic o);
        vec_t v;
        v.b   = bv;
        v.cm  = cv;
        v.clr = cl;
        v.st  = s;
        v.o   = o;
        q.push_back(v);
    endtask

    // Masks, clear and expectations are delayed by LAT so they line
    // up with the synchronised view of b.
    task automatic run(input string tag);
        logic [1:0] es;
        logic       eo;
        for (int i = 0; i < q.size() + LAT; i++) begin
            @(posedge clk);
            #1;
            b = (i < q.size()) ? q[i].b : 3'b000;
            if (i >= LAT) begin
                cm  = q[i-LAT].cm;
                clr = q[i-LAT].clr;
                es  = q[i-LAT].st;
                eo  = q[i-LAT].o;
            end else begin
                cm  = 3'b010;
                clr = 1'b0;
                es  = 2'd0;
                eo  = 1'b0;
            end
            #1;
            check_eq({tag, ".st"}, 32'(st), 32'(es));
            check_eq({tag, ".o"}, 32'(outp), 32'(eo));
            check_eq({tag, ".busy"}, 32'(busy), 32'(es != 2'd0));
            check_eq({tag, ".st2"}, 32'(st2), 32'(es));
        end
        q.delete();
        check_eq({tag, ".hit"}, 32'(hit), 32'(exp_hits));
        check_eq({tag, ".hit2"}, 32'(hit2),
                 32'((exp_hits > 3) ? 3 : exp_hits));
    endtask

    task automatic legacy(input logic clr_at_check);
        add(3'b001, 3'b010, 1'b0, 2'd0, 1'b0);
        add(3'b010, 3'b010, 1'b0, 2'd1, 1'b0);
        add(3'b010, 3'b010, 1'b0, 2'd1, 1'b0);
        add(3'b010, 3'b010, clr_at_check, 2'd2, 1'b1);
        add(3'b010, 3'b010, 1'b0, 2'd3, 1'b0);
        add(3'b010, 3'b010, 1'b0, 2'd3, 1'b0);
        add(3'b010, 3'b010, 1'b0, 2'd3, 1'b0);
        add(3'b000, 3'b010, 1'b0, 2'd3, 1'b0);
        add(3'b000, 3'b010, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        b     = 3'b000;
        tm    = 3'b011;
        cm    = 3'b010;
        clr   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst.st", 32'(st), 32'd0);
        check_eq("rst.o", 32'(outp), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.hit", 32'(hit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while in ARM.
        @(posedge clk);
        #1;
        b = 3'b001;
        #1;
        check_eq("rarm.idle", 32'(st), 32'd0);
        for (int i = 0; i < LAT + 1; i++) begin
            @(posedge clk);
            #1;
            b = 3'b000;
        end
        #1;
        check_eq("rarm.arm", 32'(st), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rarm.st", 32'(st), 32'd0);
        check_eq("rarm.o", 32'(outp), 32'd0);
        check_eq("rarm.busy", 32'(busy), 32'd0);
        check_eq("rarm.hit", 32'(hit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Legacy timing with default masks.
        exp_hits = 1;
        legacy(1'b0);
        run("legacy");

        // Modifier plus trigger held: early Mealy pulse, no confirm.
        add(3'b101, 3'b010, 1'b0, 2'd0, 1'b0);
        add(3'b101, 3'b010, 1'b0, 2'd1, 1'b0);
        add(3'b101, 3'b010, 1'b0, 2'd1, 1'b1);
        add(3'b000, 3'b010, 1'b0, 2'd2, 1'b1);
        add(3'b000, 3'b010, 1'b0, 2'd0, 1'b0);
        run("mealy");

        // Modifier alone never triggers.
        add(3'b100, 3'b010, 1'b0, 2'd0, 1'b0);
        add(3'b100, 3'b010, 1'b0, 2'd0, 1'b0);
        add(3'b000, 3'b010, 1'b0, 2'd0, 1'b0);
        run("modonly");

        // conf_mask changed during ARM has no effect.
        exp_hits = 2;
        add(3'b001, 3'b010, 1'b0, 2'd0, 1'b0);
        add(3'b010, 3'b001, 1'b0, 2'd1, 1'b0);
        add(3'b010, 3'b001, 1'b0, 2'd1, 1'b0);
        add(3'b010, 3'b001, 1'b0, 2'd2, 1'b1);
        add(3'b010, 3'b001, 1'b0, 2'd3, 1'b0);
        add(3'b010, 3'b001, 1'b0, 2'd3, 1'b0);
        add(3'b010, 3'b001, 1'b0, 2'd3, 1'b0);
        add(3'b000, 3'b010, 1'b0, 2'd3, 1'b0);
        add(3'b000, 3'b010, 1'b0, 2'd0, 1'b0);
        run("latch");

        // Three more hits: 8-bit reads 5, 2-bit saturates at 3.
        for (int k = 0; k < 3; k++) begin
            exp_hits++;
            legacy(1'b0);
            run("sat");
        end

        // Clear coincides with a hit: clear wins.
        exp_hits = 0;
        legacy(1'b1);
        run("clr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
